age_ordered_pool_arbiter: RTL and testbench

- Shares a pool of NUM_UNITS identical execution units (ALUs) among NUM_PORTS single-instruction controllers.
- Grants are made in program order, oldest issue ID first, using wrap-around ID comparison.
- Each grant is held until the owner releases it or a rollback flush kills it.
- Sits between the SIC array and the ALU pool. It replaces ad-hoc lock arbitration with one registered grant/owner table and adds a hold watchdog.

---
 rtl/age_ordered_pool_arbiter_pkg.sv | 25 ++
 rtl/age_ordered_pool_arbiter_if.sv | 30 +++
 rtl/age_ordered_pool_arbiter_age_sort_selector.sv | 31 +++
 rtl/age_ordered_pool_arbiter.sv | 129 ++++++++++++
 tb/tb_age_ordered_pool_arbiter.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/age_ordered_pool_arbiter_pkg.sv
// rtl/age_ordered_pool_arbiter_pkg.sv - shared types and helpers for the ALU pool arbiter
package age_ordered_pool_arbiter_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      HELD = 1'b1
   } pool_port_state_e;

   localparam int MAX_ID_WIDTH = 64;

   // Index width for a pool of n entries; never below one bit so a single-unit pool still has a port.
   function automatic int unit_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Wrap-around age compare: a is older than b when (a-b) mod 2^w has its top bit set.
   function automatic logic id_older(input logic [MAX_ID_WIDTH-1:0] a,
                                     input logic [MAX_ID_WIDTH-1:0] b,
                                     input int                      w);
      logic [MAX_ID_WIDTH-1:0] diff;
      diff = a - b;
      return (a != b) && diff[6'(w - 1)];
   endfunction

endpackage

// File: rtl/age_ordered_pool_arbiter_if.sv
// rtl/age_ordered_pool_arbiter_if.sv - request/grant bundle between the SIC array and the pool arbiter
interface age_ordered_pool_arbiter_if
   import age_ordered_pool_arbiter_pkg::*;
#(
   parameter int NUM_PORTS = 2,
   parameter int NUM_UNITS = 4,
   parameter int ID_WIDTH  = 16
);
   localparam int UW = unit_idx_w(NUM_UNITS);

   logic [NUM_PORTS-1:0]               req_valid;
   logic [NUM_PORTS-1:0][ID_WIDTH-1:0] req_id;
   logic [NUM_PORTS-1:0]               req_release;
   logic                               flush_valid;
   logic [ID_WIDTH-1:0]                flush_id;
   logic [NUM_PORTS-1:0]               grant;
   logic [NUM_PORTS-1:0][UW-1:0]       grant_unit;
   logic [NUM_UNITS-1:0]               unit_busy;
   logic                               hold_timeout;

   modport master (
      output req_valid, req_id, req_release, flush_valid, flush_id,
      input  grant, grant_unit, unit_busy, hold_timeout
   );

   modport slave (
      input  req_valid, req_id, req_release, flush_valid, flush_id,
      output grant, grant_unit, unit_busy, hold_timeout
   );
endinterface

// File: rtl/age_ordered_pool_arbiter_age_sort_selector.sv
// rtl/age_ordered_pool_arbiter_age_sort_selector.sv - oldest-first rank of each candidate port
module age_sort_selector
   import age_ordered_pool_arbiter_pkg::*;
#(
   parameter int NUM_PORTS = 2,
   parameter int ID_WIDTH  = 16,
   parameter int RW        = 1
) (
   input  logic [NUM_PORTS-1:0]               cand_i,
   input  logic [NUM_PORTS-1:0][ID_WIDTH-1:0] id_i,
   output logic [NUM_PORTS-1:0][RW-1:0]       rank_o
);
   int older_cnt;

   // Rank = number of candidates ahead of this port; equal IDs yield to the lower port index.
   always_comb begin
      older_cnt = 0;
      rank_o    = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         older_cnt = 0;
         for (int q = 0; q < NUM_PORTS; q++) begin
            if (cand_i[q] &&
                (id_older(MAX_ID_WIDTH'(id_i[q]), MAX_ID_WIDTH'(id_i[p]), ID_WIDTH) ||
                 ((id_i[q] == id_i[p]) && (q < p)))) begin
               older_cnt = older_cnt + 1;
            end
         end
         rank_o[p] = RW'(older_cnt);
      end
   end
endmodule

// File: rtl/age_ordered_pool_arbiter.sv
// rtl/age_ordered_pool_arbiter.sv - age-ordered grant/owner table for a shared ALU pool with hold watchdog
module age_ordered_pool_arbiter
   import age_ordered_pool_arbiter_pkg::*;
#(
   parameter int NUM_PORTS = 2,
   parameter int NUM_UNITS = 4,
   parameter int ID_WIDTH  = 16,
   parameter int MAX_HOLD  = 64
) (
   input  logic                          clk,
   input  logic                          rst,
   age_ordered_pool_arbiter_if.slave     bus
);
   localparam int UW = unit_idx_w(NUM_UNITS);
   localparam int RW = unit_idx_w(NUM_PORTS);
   localparam int CW = $clog2(MAX_HOLD + 1);

   pool_port_state_e                   state_q [NUM_PORTS];
   pool_port_state_e                   state_d [NUM_PORTS];
   logic [NUM_PORTS-1:0][UW-1:0]       unit_q, unit_d;
   logic [NUM_PORTS-1:0][ID_WIDTH-1:0] held_id_q, held_id_d;
   logic [NUM_UNITS-1:0]               busy_q, busy_d;
   logic [NUM_UNITS-1:0][CW-1:0]       cnt_q, cnt_d;
   logic                               timeout_q, timeout_d;

   logic [NUM_PORTS-1:0]               cand;
   logic [NUM_PORTS-1:0]               drop;
   logic [NUM_PORTS-1:0][RW-1:0]       rank;
   int                                 free_cnt;
   int                                 free_ord [NUM_UNITS];

   always_comb begin
      cand = '0;
      drop = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         cand[p] = (state_q[p] == IDLE) && bus.req_valid[p] &&
                   !(bus.flush_valid && id_older(MAX_ID_WIDTH'(bus.flush_id),
                                                 MAX_ID_WIDTH'(bus.req_id[p]), ID_WIDTH));
         drop[p] = (state_q[p] == HELD) &&
                   (bus.req_release[p] ||
                    (bus.flush_valid && id_older(MAX_ID_WIDTH'(bus.flush_id),
                                                 MAX_ID_WIDTH'(held_id_q[p]), ID_WIDTH)));
      end
   end

   age_sort_selector #(
      .NUM_PORTS (NUM_PORTS),
      .ID_WIDTH  (ID_WIDTH),
      .RW        (RW)
   ) u_sort (
      .cand_i (cand),
      .id_i   (bus.req_id),
      .rank_o (rank)
   );

   always_comb begin
      state_d   = state_q;
      unit_d    = unit_q;
      held_id_d = held_id_q;
      busy_d    = busy_q;
      cnt_d     = cnt_q;
      timeout_d = timeout_q;
      free_cnt  = 0;

      // free_ord[u] is this unit's position among free units, so rank r takes the r-th free unit.
      for (int u = 0; u < NUM_UNITS; u++) begin
         free_ord[u] = free_cnt;
         if (!busy_q[u]) free_cnt = free_cnt + 1;
         if (busy_q[u] && (cnt_q[u] != CW'(MAX_HOLD))) cnt_d[u] = cnt_q[u] + 1'b1;
         if (busy_q[u] && (cnt_q[u] == CW'(MAX_HOLD))) timeout_d = 1'b1;
      end

      for (int p = 0; p < NUM_PORTS; p++) begin
         if (drop[p]) begin
            state_d[p]        = IDLE;
            busy_d[unit_q[p]] = 1'b0;
            cnt_d[unit_q[p]]  = '0;
         end else if (cand[p]) begin
            for (int u = 0; u < NUM_UNITS; u++) begin
               if (!busy_q[u] && (free_ord[u] == int'(rank[p]))) begin
                  state_d[p]   = HELD;
                  unit_d[p]    = UW'(u);
                  held_id_d[p] = bus.req_id[p];
                  busy_d[u]    = 1'b1;
                  cnt_d[u]     = '0;
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int p = 0; p < NUM_PORTS; p++) state_q[p] <= IDLE;
         unit_q    <= '0;
         held_id_q <= '0;
         busy_q    <= '0;
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         for (int p = 0; p < NUM_PORTS; p++) state_q[p] <= state_d[p];
         unit_q    <= unit_d;
         held_id_q <= held_id_d;
         busy_q    <= busy_d;
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   always_comb begin
      for (int p = 0; p < NUM_PORTS; p++) bus.grant[p] = (state_q[p] == HELD);
   end
   assign bus.grant_unit   = unit_q;
   assign bus.unit_busy    = busy_q;
   assign bus.hold_timeout = timeout_q;

   logic dup_unit;
   always_comb begin
      dup_unit = 1'b0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         for (int q = p + 1; q < NUM_PORTS; q++) begin
            if ((state_q[p] == HELD) && (state_q[q] == HELD) && (unit_q[p] == unit_q[q]))
               dup_unit = 1'b1;
         end
      end
   end

   a_unique_owner: assert property (@(posedge clk) disable iff (rst) !dup_unit);
endmodule

// File: tb/tb_age_ordered_pool_arbiter.sv
// tb/tb_age_ordered_pool_arbiter.sv - scoreboard bench for age_ordered_pool_arbiter
module tb_age_ordered_pool_arbiter;
   localparam int K_GRANT = 0;
   localparam int K_UNIT  = 1;
   localparam int K_BUSY  = 2;
   localparam int K_TO    = 3;
   localparam int DA      = 0;
   localparam int DB      = 1;

   typedef struct {
      string       tag;
      int          dut;
      int          kind;
      int          idx;
      logic [31:0] val;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t exp_q [$];

   always #5 clk = ~clk;

   age_ordered_pool_arbiter_if #(.NUM_PORTS(2), .NUM_UNITS(4), .ID_WIDTH(16)) a_if ();
   age_ordered_pool_arbiter_if #(.NUM_PORTS(2), .NUM_UNITS(1), .ID_WIDTH(16)) b_if ();

   age_ordered_pool_arbiter #(.NUM_PORTS(2), .NUM_UNITS(4), .ID_WIDTH(16), .MAX_HOLD(64)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (a_if.slave)
   );

   age_ordered_pool_arbiter #(.NUM_PORTS(2), .NUM_UNITS(1), .ID_WIDTH(16), .MAX_HOLD(4)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (b_if.slave)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] observe(input int dut, input int kind, input int idx);
      if (dut == DA) begin
         case (kind)
            K_GRANT: return 32'(a_if.grant);
            K_UNIT:  return 32'(a_if.grant_unit[idx]);
            K_BUSY:  return 32'(a_if.unit_busy);
            default: return 32'(a_if.hold_timeout);
         endcase
      end else begin
         case (kind)
            K_GRANT: return 32'(b_if.grant);
            K_UNIT:  return 32'(b_if.grant_unit[idx]);
            K_BUSY:  return 32'(b_if.unit_busy);
            default: return 32'(b_if.hold_timeout);
         endcase
      end
   endfunction

   task automatic ex(input string tag, input int dut, input int kind, input int idx, input logic [31:0] v);
      exp_q.push_back('{tag: tag, dut: dut, kind: kind, idx: idx, val: v});
   endtask

   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check_eq(e.tag, observe(e.dut, e.kind, e.idx), e.val);
      end
   endtask

   task automatic idle_inputs();
      a_if.req_valid = '0; a_if.req_release = '0; a_if.flush_valid = 1'b0;
      b_if.req_valid = '0; b_if.req_release = '0; b_if.flush_valid = 1'b0;
   endtask

   initial begin
      a_if.req_id = '0; a_if.flush_id = '0;
      b_if.req_id = '0; b_if.flush_id = '0;
      idle_inputs();

      tick();
      for (int d = 0; d < 2; d++) begin
         ex("rst_grant", d, K_GRANT, 0, 0);
         ex("rst_unit",  d, K_UNIT,  0, 0);
         ex("rst_busy",  d, K_BUSY,  0, 0);
         ex("rst_to",    d, K_TO,    0, 0);
      end
      tick();
      rst = 1'b0;

      // older id 3 on port1 takes unit 0
      a_if.req_valid = 2'b11; a_if.req_id[0] = 16'd5; a_if.req_id[1] = 16'd3;
      ex("t1_grant", DA, K_GRANT, 0, 2'b11);
      ex("t1_unit1", DA, K_UNIT,  1, 0);
      ex("t1_unit0", DA, K_UNIT,  0, 1);
      ex("t1_busy",  DA, K_BUSY,  0, 4'b0011);
      tick();
      a_if.req_valid = 2'b01; a_if.req_id[0] = 16'd77;
      ex("held_req_grant", DA, K_GRANT, 0, 2'b11);
      ex("held_req_unit0", DA, K_UNIT,  0, 1);
      ex("held_req_busy",  DA, K_BUSY,  0, 4'b0011);
      tick();
      a_if.req_valid = 2'b00; a_if.req_release = 2'b11;
      ex("rel_both_grant", DA, K_GRANT, 0, 0);
      ex("rel_both_busy",  DA, K_BUSY,  0, 0);
      tick();
      a_if.req_release = 2'b01; a_if.req_valid = 2'b01; a_if.req_id[0] = 16'd9;
      ex("rel_idle_req_grant", DA, K_GRANT, 0, 2'b01);
      ex("rel_idle_req_unit0", DA, K_UNIT,  0, 0);
      ex("rel_idle_req_busy",  DA, K_BUSY,  0, 4'b0001);
      tick();
      a_if.req_valid = 2'b00; a_if.req_release = 2'b10;
      ex("rel_idle_grant", DA, K_GRANT, 0, 2'b01);
      ex("rel_idle_busy",  DA, K_BUSY,  0, 4'b0001);
      tick();
      a_if.req_release = 2'b01;
      ex("rel0_grant", DA, K_GRANT, 0, 0);
      ex("rel0_busy",  DA, K_BUSY,  0, 0);
      tick();
      a_if.req_release = 2'b00;

      // equal IDs fall back to port index
      a_if.req_valid = 2'b11; a_if.req_id[0] = 16'd100; a_if.req_id[1] = 16'd100;
      ex("tie_unit0", DA, K_UNIT, 0, 0);
      ex("tie_unit1", DA, K_UNIT, 1, 1);
      tick();
      a_if.req_valid = 2'b00; a_if.req_release = 2'b11;
      ex("tie_rel_busy", DA, K_BUSY, 0, 0);
      tick();
      a_if.req_release = 2'b00;

      a_if.req_valid = 2'b11; a_if.req_id[0] = 16'd10; a_if.req_id[1] = 16'd20;
      ex("fl_setup_grant", DA, K_GRANT, 0, 2'b11);
      ex("fl_setup_unit1", DA, K_UNIT,  1, 1);
      tick();
      a_if.req_valid = 2'b00; a_if.flush_valid = 1'b1; a_if.flush_id = 16'd10;
      ex("flush_grant", DA, K_GRANT, 0, 2'b01);
      ex("flush_busy",  DA, K_BUSY,  0, 4'b0001);
      tick();
      a_if.flush_valid = 1'b0; a_if.req_release = 2'b01;
      ex("fl_rel_busy", DA, K_BUSY, 0, 0);
      tick();
      a_if.req_release = 2'b00;
      a_if.req_valid = 2'b01; a_if.req_id[0] = 16'd30; a_if.flush_valid = 1'b1;
      ex("flush_cand_grant", DA, K_GRANT, 0, 0);
      ex("flush_cand_busy",  DA, K_BUSY,  0, 0);
      tick();
      idle_inputs();

      // single unit: wrapped ID 0xFFFE is older than 0x0002
      b_if.req_valid = 2'b11; b_if.req_id[0] = 16'h0002; b_if.req_id[1] = 16'hFFFE;
      ex("wrap_grant", DB, K_GRANT, 0, 2'b10);
      ex("wrap_unit1", DB, K_UNIT,  1, 0);
      ex("wrap_busy",  DB, K_BUSY,  0, 1);
      tick();
      b_if.req_valid = 2'b01;
      ex("wrap_wait1", DB, K_GRANT, 0, 2'b10);
      tick();
      ex("wrap_wait2", DB, K_GRANT, 0, 2'b10);
      tick();
      b_if.req_release = 2'b10;
      ex("wrap_rel_grant", DB, K_GRANT, 0, 0);
      ex("wrap_rel_busy",  DB, K_BUSY,  0, 0);
      tick();
      b_if.req_release = 2'b00;
      ex("wrap_p0_grant", DB, K_GRANT, 0, 2'b01);
      ex("wrap_p0_unit",  DB, K_UNIT,  0, 0);
      ex("wrap_p0_busy",  DB, K_BUSY,  0, 1);
      tick();
      b_if.req_valid = 2'b00; b_if.req_release = 2'b01;
      ex("wrap_p0_rel", DB, K_BUSY, 0, 0);
      tick();
      b_if.req_release = 2'b00;

      b_if.req_valid = 2'b01; b_if.req_id[0] = 16'd7;
      ex("rf_setup_grant", DB, K_GRANT, 0, 2'b01);
      tick();
      b_if.req_valid = 2'b00; b_if.req_release = 2'b01;
      b_if.flush_valid = 1'b1; b_if.flush_id = 16'd3;
      ex("rel_flush_grant", DB, K_GRANT, 0, 0);
      ex("rel_flush_busy",  DB, K_BUSY,  0, 0);
      ex("rel_flush_to",    DB, K_TO,    0, 0);
      tick();
      idle_inputs();

      b_if.req_valid = 2'b01; b_if.req_id[0] = 16'd50;
      ex("wd_grant", DB, K_GRANT, 0, 2'b01);
      tick();
      b_if.req_valid = 2'b00;
      for (int i = 1; i <= 4; i++) begin
         ex($sformatf("wd_quiet%0d", i), DB, K_TO, 0, 0);
         tick();
      end
      ex("wd_fire",      DB, K_TO,    0, 1);
      ex("wd_keep_busy", DB, K_BUSY,  0, 1);
      tick();
      ex("wd_sticky", DB, K_TO, 0, 1);
      tick();

      rst = 1'b1;
      for (int d = 0; d < 2; d++) begin
         ex("mid_rst_grant", d, K_GRANT, 0, 0);
         ex("mid_rst_busy",  d, K_BUSY,  0, 0);
         ex("mid_rst_to",    d, K_TO,    0, 0);
      end
      tick();
      rst = 1'b0;
      b_if.req_valid = 2'b10; b_if.req_id[1] = 16'd1;
      ex("post_rst_grant", DB, K_GRANT, 0, 2'b10);
      ex("post_rst_unit1", DB, K_UNIT,  1, 0);
      tick();
      idle_inputs();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
